iserdes_loop_align: RTL and testbench
=====================================

Name: iserdes_loop_align

Overview:
- Multi-channel alignment controller for ISERDES loopback/training inputs, running in the CLK_BUFR (divided) domain.
- Per channel, in sequence: sweeps the variable IDELAY tap, finds the widest stable window, loads its centre tap, then issues BITSLIP pulses until the deserialized word equals the training pattern.
- Generalises the fixed-tap single-channel loop to NCH channels with run-time delay and word alignment.

Parameters:
- NCH, 4, number of channels aligned, serviced sequentially 0..NCH-1
- DATA_WIDTH, 4, deserialized word width per channel
- TRAIN_PATTERN, 4'b1100, expected aligned word (DATA_WIDTH bits)
- TAP_BITS, 5, IDELAY tap field width
- MAX_TAP, 31, highest tap swept
- SETTLE_CYCLES, 8, wait after any tap load or bitslip before sampling (>=2)
- MATCH_COUNT, 16, consecutive identical words that make a tap "good"

Ports:
- CLK_BUFR  in  1  divided clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; begins alignment of all channels
- Q  in  NCH*DATA_WIDTH  ISERDES words; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- BITSLIP  out  NCH  one-cycle bitslip pulse per channel
- DELAY_LD  out  NCH  one-cycle IDELAY load strobe per channel
- DELAY_VALUE  out  TAP_BITS  tap value shared by all channels, qualified by DELAY_LD
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  sticky; set when all channels are finished, cleared by START
- LOCKED  out  NCH  channel aligned at centre tap with pattern matched
- FAIL  out  NCH  channel found no good tap, or no slip matched

Behaviour:
- Reset: every output is 0; FSM is IDLE; channel index, tap and all counters are 0. Reset asserted mid-run aborts immediately with the same values.
- IDLE: START -> LOAD. START also clears DONE, LOCKED and FAIL, and sets ch=0, tap=0 and the run trackers to 0. START while BUSY is ignored.
- LOAD: DELAY_VALUE=tap and DELAY_LD[ch]=1 for exactly one cycle -> SETTLE.
- SETTLE: count SETTLE_CYCLES -> SAMPLE.
- SAMPLE: capture the first word as a reference.
  - Any following word != reference: tap is bad.
  - MATCH_COUNT total equal words (reference included): tap is good.
  - Exit takes ≤MATCH_COUNT cycles -> NEXT_TAP.
- NEXT_TAP run tracking:
  - Good tap: cur_len += 1, with cur_start = tap if cur_len was 0.
  - Bad tap, or tap == MAX_TAP: if cur_len > best_len then best := cur (strictly greater, so ties keep the earlier run). A bad tap then clears cur_len.
  - Tap < MAX_TAP: tap += 1 -> LOAD. Otherwise -> CENTER.
- CENTER:
  - best_len == 0: FAIL[ch]=1 -> CH_DONE.
  - Otherwise tap = best_start + (best_len >> 1) (floor); one DELAY_LD pulse; settle; slip_cnt=0 -> SLIP_CHECK.
- SLIP_CHECK: compare MATCH_COUNT consecutive words against TRAIN_PATTERN.
  - All match: LOCKED[ch]=1 -> CH_DONE.
  - Mismatch and slip_cnt < DATA_WIDTH: BITSLIP[ch]=1 for one cycle, slip_cnt += 1, SETTLE_CYCLES wait -> SLIP_CHECK.
  - Mismatch and slip_cnt == DATA_WIDTH: FAIL[ch]=1 -> CH_DONE.
- CH_DONE: ch == NCH-1 -> ALL_DONE. Otherwise ch += 1, tap=0, trackers reset -> LOAD.
- ALL_DONE: BUSY=0, DONE=1 -> IDLE.
- Output rules:
  - At most one BITSLIP or DELAY_LD bit is high in any cycle, and only for the active channel.
  - Consecutive BITSLIP pulses on one channel are ≥SETTLE_CYCLES+1 cycles apart.
  - LOCKED and FAIL are mutually exclusive per channel.
- Arithmetic: tap and cur/best fields are TAP_BITS+1 wide internally, so an all-good sweep gives best_len = MAX_TAP+1 without wrap.

Optional Feature:
- Macro: ISERDES_ALIGN_STATS_EN.
- Defined:
  - Adds output EYE_WIDTH (NCH*(TAP_BITS+1)) holding best_len per channel, latched at CENTER.
  - Adds output CENTER_TAP (NCH*TAP_BITS) holding the chosen centre tap.
  - Both reset to 0 and are cleared by START.
- Undefined: neither port exists. Alignment behaviour is identical either way.

Test Plan:
- Channel 0 stable for taps 8..19, unstable elsewhere, correct word after 2 slips -> one DELAY_LD per tap 0..31, then centre tap 14 loaded, exactly 2 BITSLIP pulses ≥9 cycles apart, LOCKED[0]=1, DONE=1.
- Two good windows, taps 3..6 and 20..23 (equal length 4) -> earlier run wins, centre tap 5.
- All taps unstable on channel 1 -> FAIL[1]=1, no BITSLIP[1], remaining channels still processed, DONE=1.
- All taps stable but pattern never matches -> exactly DATA_WIDTH (4) slips, then FAIL=1; with STATS on, EYE_WIDTH=32 and CENTER_TAP=16.
- RST_N pulsed low mid-sweep, then START -> all outputs 0 during reset; a full clean re-run completes with correct LOCKED.
- START re-pulsed while BUSY -> ignored, no state disturbance; START after DONE clears DONE, LOCKED and FAIL in the next cycle.

Source files
------------

// File: rtl/iserdes_loop_align_if.sv
// Bus bundle for iserdes_loop_align: start/status, ISERDES word input and
// IDELAY/BITSLIP controls. ISERDES_ALIGN_STATS_EN adds EYE_WIDTH and CENTER_TAP.
interface iserdes_loop_align_if #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned TAP_BITS   = 5
);
  logic                      START;
  logic [NCH*DATA_WIDTH-1:0] Q;
  logic [NCH-1:0]            BITSLIP;
  logic [NCH-1:0]            DELAY_LD;
  logic [TAP_BITS-1:0]       DELAY_VALUE;
  logic                      BUSY;
  logic                      DONE;
  logic [NCH-1:0]            LOCKED;
  logic [NCH-1:0]            FAIL;
`ifdef ISERDES_ALIGN_STATS_EN
  logic [NCH*(TAP_BITS+1)-1:0] EYE_WIDTH;
  logic [NCH*TAP_BITS-1:0]     CENTER_TAP;

  modport master (output START, Q,
                  input  BITSLIP, DELAY_LD, DELAY_VALUE, BUSY, DONE, LOCKED, FAIL,
                         EYE_WIDTH, CENTER_TAP);
  modport slave  (input  START, Q,
                  output BITSLIP, DELAY_LD, DELAY_VALUE, BUSY, DONE, LOCKED, FAIL,
                         EYE_WIDTH, CENTER_TAP);
`else
  modport master (output START, Q,
                  input  BITSLIP, DELAY_LD, DELAY_VALUE, BUSY, DONE, LOCKED, FAIL);
  modport slave  (input  START, Q,
                  output BITSLIP, DELAY_LD, DELAY_VALUE, BUSY, DONE, LOCKED, FAIL);
`endif
endinterface

// File: rtl/iserdes_loop_align.sv
// Multi-channel ISERDES alignment: per channel, sweep IDELAY taps, pick the
// centre of the widest stable window, then bitslip until the training pattern
// is seen. Optional per-channel eye statistics under ISERDES_ALIGN_STATS_EN.
module iserdes_loop_align #(
  parameter int unsigned          NCH           = 4,
  parameter int unsigned          DATA_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 4'b1100,
  parameter int unsigned          TAP_BITS      = 5,
  parameter int unsigned          MAX_TAP       = 31,
  parameter int unsigned          SETTLE_CYCLES = 8,
  parameter int unsigned          MATCH_COUNT   = 16
) (
  input  logic                CLK_BUFR,
  input  logic                RST_N,
  iserdes_loop_align_if.slave bus
);
  localparam int unsigned TW   = TAP_BITS + 1;
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CMAX = (SETTLE_CYCLES > MATCH_COUNT) ? SETTLE_CYCLES : MATCH_COUNT;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned SW   = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0]  TAP_LAST    = TW'(MAX_TAP);
  localparam logic [CHW-1:0] CH_LAST     = CHW'(NCH - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  MATCH_LAST  = CW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0]  SLIP_MAX    = SW'(DATA_WIDTH);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_NEXT_TAP, S_CENTER, S_CLOAD,
    S_SLIP, S_SWAIT, S_SLIP_CHECK, S_CH_DONE, S_ALL_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [TW-1:0]         tap_q, tap_d;
  logic [TW-1:0]         cur_start_q, cur_start_d, cur_len_q, cur_len_d;
  logic [TW-1:0]         best_start_q, best_start_d, best_len_q, best_len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         slip_q, slip_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic                  good_q, good_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [NCH-1:0]        locked_q, locked_d, fail_q, fail_d;
  logic [DATA_WIDTH-1:0] word;
  logic [NCH-1:0]        ch_sel;
  logic [TW-1:0]         center_tap;
  logic [TW-1:0]         run_start, run_len;
`ifdef ISERDES_ALIGN_STATS_EN
  logic [NCH*TW-1:0]       eye_q, eye_d;
  logic [NCH*TAP_BITS-1:0] ctr_q, ctr_d;

  assign bus.EYE_WIDTH  = eye_q;
  assign bus.CENTER_TAP = ctr_q;
`endif

  assign word       = bus.Q[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign ch_sel     = NCH'(1) << ch_q;
  assign center_tap = best_start_q + (best_len_q >> 1);

  assign bus.DELAY_LD    = (state_q == S_LOAD || state_q == S_CLOAD) ? ch_sel : '0;
  assign bus.BITSLIP     = (state_q == S_SLIP) ? ch_sel : '0;
  assign bus.DELAY_VALUE = tap_q[TAP_BITS-1:0];
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.LOCKED      = locked_q;
  assign bus.FAIL        = fail_q;

  // State and datapath registers
  always_ff @(posedge CLK_BUFR or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      tap_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      cnt_q        <= '0;
      slip_q       <= '0;
      ref_q        <= '0;
      good_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= '0;
      fail_q       <= '0;
`ifdef ISERDES_ALIGN_STATS_EN
      eye_q        <= '0;
      ctr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tap_q        <= tap_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      cnt_q        <= cnt_d;
      slip_q       <= slip_d;
      ref_q        <= ref_d;
      good_q       <= good_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
`ifdef ISERDES_ALIGN_STATS_EN
      eye_q        <= eye_d;
      ctr_q        <= ctr_d;
`endif
    end
  end

  // Next-state logic: tap sweep, window tracking, centring and bitslip search
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tap_d        = tap_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cnt_d        = cnt_q;
    slip_d       = slip_q;
    ref_d        = ref_q;
    good_d       = good_q;
    busy_d       = busy_q;
    done_d       = done_q;
    locked_d     = locked_q;
    fail_d       = fail_q;
    run_start    = cur_start_q;
    run_len      = cur_len_q;
`ifdef ISERDES_ALIGN_STATS_EN
    eye_d        = eye_q;
    ctr_d        = ctr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          busy_d       = 1'b1;
          done_d       = 1'b0;
          locked_d     = '0;
          fail_d       = '0;
          ch_d         = '0;
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          cnt_d        = '0;
`ifdef ISERDES_ALIGN_STATS_EN
          eye_d        = '0;
          ctr_d        = '0;
`endif
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) ref_d = word;
        if (cnt_q == '0 || word == ref_q) begin
          if (cnt_q == MATCH_LAST) begin
            good_d  = 1'b1;
            state_d = S_NEXT_TAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          good_d  = 1'b0;
          state_d = S_NEXT_TAP;
        end
      end
      S_NEXT_TAP: begin
        // Run is extended first so a good last tap is counted before the
        // end-of-sweep comparison against the best run.
        if (good_q) begin
          if (cur_len_q == '0) run_start = tap_q;
          run_len = cur_len_q + 1'b1;
        end
        cur_start_d = run_start;
        cur_len_d   = run_len;
        if (!good_q || tap_q == TAP_LAST) begin
          if (run_len > best_len_q) begin
            best_start_d = run_start;
            best_len_d   = run_len;
          end
          if (!good_q) cur_len_d = '0;
        end
        cnt_d = '0;
        if (tap_q == TAP_LAST) begin
          state_d = S_CENTER;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_CENTER: begin
        slip_d = '0;
        cnt_d  = '0;
`ifdef ISERDES_ALIGN_STATS_EN
        eye_d[ch_q*TW +: TW]             = best_len_q;
        ctr_d[ch_q*TAP_BITS +: TAP_BITS] = center_tap[TAP_BITS-1:0];
`endif
        if (best_len_q == '0) begin
          fail_d[ch_q] = 1'b1;
          state_d      = S_CH_DONE;
        end else begin
          tap_d   = center_tap;
          state_d = S_CLOAD;
        end
      end
      S_CLOAD: begin
        cnt_d   = '0;
        state_d = S_SWAIT;
      end
      S_SLIP: begin
        slip_d  = slip_q + 1'b1;
        cnt_d   = '0;
        state_d = S_SWAIT;
      end
      S_SWAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SLIP_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SLIP_CHECK: begin
        if (word == TRAIN_PATTERN) begin
          if (cnt_q == MATCH_LAST) begin
            locked_d[ch_q] = 1'b1;
            state_d        = S_CH_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (slip_q == SLIP_MAX) begin
            fail_d[ch_q] = 1'b1;
            state_d      = S_CH_DONE;
          end else begin
            state_d = S_SLIP;
          end
        end
      end
      S_CH_DONE: begin
        if (ch_q == CH_LAST) begin
          state_d = S_ALL_DONE;
        end else begin
          ch_d         = ch_q + 1'b1;
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          cnt_d        = '0;
          state_d      = S_LOAD;
        end
      end
      S_ALL_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_iserdes_loop_align.sv
// Scoreboard bench for iserdes_loop_align: a behavioural ISERDES/IDELAY model
// feeds Q, expected DELAY_LD/BITSLIP/DONE events are queued per run and a
// monitor pops and compares them as the DUT presents them.
module tb_iserdes_loop_align;
  localparam int NCH    = 4;
  localparam int DW     = 4;
  localparam int SETTLE = 8;
  localparam logic [3:0] TRAIN = 4'b1100;

  typedef struct {
    int           kind;   // 0 = DELAY_LD, 1 = BITSLIP, 2 = DONE
    int           ch;
    int           val;
    logic [23:0]  eye;
    logic [19:0]  ctap;
  } ev_t;

  logic clk;
  logic RST_N;
  iserdes_loop_align_if #(.NCH(NCH), .DATA_WIDTH(DW), .TAP_BITS(5)) bus ();

  iserdes_loop_align #(
    .NCH(NCH), .DATA_WIDTH(DW), .TRAIN_PATTERN(4'b1100), .TAP_BITS(5),
    .MAX_TAP(31), .SETTLE_CYCLES(SETTLE), .MATCH_COUNT(16)
  ) dut (
    .CLK_BUFR(clk),
    .RST_N   (RST_N),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  ev_t exp_q[$];

  // Scenario tables (hand-computed): 0 = mixed windows, 1 = boundary windows
  logic [31:0] sc_mask [2][NCH] = '{'{32'h000F_FF00, 32'h00F0_0078, 32'h0000_0000, 32'hFFFF_FFFF},
                                    '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0007_F3E0}};
  int sc_need   [2][NCH] = '{'{2, 0, 0, -1}, '{0, 3, 1, 0}};
  int sc_centre [2][NCH] = '{'{14, 5, -1, 16}, '{16, 0, 31, 15}};
  int sc_slips  [2][NCH] = '{'{2, 0, 0, 4}, '{0, 3, 1, 0}};
  logic [3:0]  sc_locked [2] = '{4'b0011, 4'b1111};
  logic [3:0]  sc_fail   [2] = '{4'b1100, 4'b0000};
  logic [23:0] sc_eye    [2] = '{{6'd32, 6'd0, 6'd4, 6'd12}, {6'd7, 6'd1, 6'd1, 6'd32}};
  logic [19:0] sc_ctap   [2] = '{{5'd16, 5'd0, 5'd5, 5'd14}, {5'd15, 5'd31, 5'd0, 5'd16}};

  // Channel model state
  logic [31:0] cfg_mask [NCH];
  int          cfg_need [NCH];
  int          mtap     [NCH];
  int          mslip    [NCH];
  logic        tog;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Stable taps give the training word rotated by the slips still missing;
  // unstable taps alternate every cycle.
  function automatic logic [3:0] chan_word(input int c);
    logic [7:0] d;
    int r;
    if (!cfg_mask[c][mtap[c]]) return tog ? 4'b0101 : 4'b1010;
    if (cfg_need[c] < 0) return 4'b1010;
    r = (((cfg_need[c] - mslip[c]) % 4) + 4) % 4;
    d = {TRAIN, TRAIN} << r;
    return d[7:4];
  endfunction

  // ISERDES/IDELAY model: follows the DUT's load and slip strobes
  initial begin
    tog = 1'b0;
    bus.Q = '0;
    for (int c = 0; c < NCH; c++) begin
      mtap[c] = 0;
      mslip[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (bus.START && !bus.BUSY && RST_N) begin
        for (int c = 0; c < NCH; c++) begin
          mtap[c] = 0;
          mslip[c] = 0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (bus.DELAY_LD[c] === 1'b1) mtap[c] = int'(bus.DELAY_VALUE);
        if (bus.BITSLIP[c] === 1'b1) mslip[c] = mslip[c] + 1;
      end
      tog = ~tog;
      for (int c = 0; c < NCH; c++) bus.Q[c*DW +: DW] = chan_word(c);
    end
  end

  // Monitor: pops one expected event per presented strobe or DONE rise
  initial begin
    int   cyc;
    int   last_slip [NCH];
    logic done_prev;
    ev_t  e;
    cyc = 0;
    done_prev = 1'b0;
    for (int c = 0; c < NCH; c++) last_slip[c] = -1000;
    forever begin
      @(negedge clk);
      cyc++;
      if (!RST_N) begin
        done_prev = 1'b0;
      end else begin
        if ((bus.DELAY_LD | bus.BITSLIP) != '0)
          check("single_strobe", $countones(bus.DELAY_LD) + $countones(bus.BITSLIP), 1);
        for (int c = 0; c < NCH; c++) begin
          if (bus.DELAY_LD[c]) begin
            check("ld_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("ld_event", 65536 + c*256 + int'(bus.DELAY_VALUE) - 65536,
                    e.kind*65536 + e.ch*256 + e.val);
            end
          end
          if (bus.BITSLIP[c]) begin
            check("slip_gap", (cyc - last_slip[c]) > SETTLE, 1);
            last_slip[c] = cyc;
            check("slip_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("slip_event", 65536 + c*256, e.kind*65536 + e.ch*256 + e.val);
            end
          end
        end
        if (bus.DONE && !done_prev) begin
          check("done_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_event", 2*65536 + int'({bus.LOCKED, bus.FAIL}),
                  e.kind*65536 + e.val);
            check("done_busy_low", bus.BUSY, 0);
`ifdef ISERDES_ALIGN_STATS_EN
            check("eye_width", bus.EYE_WIDTH, e.eye);
            check("center_tap", bus.CENTER_TAP, e.ctap);
`endif
          end
        end
        done_prev = bus.DONE;
      end
    end
  end

  task automatic load_cfg(input int s);
    for (int c = 0; c < NCH; c++) begin
      cfg_mask[c] = sc_mask[s][c];
      cfg_need[c] = sc_need[s][c];
    end
  endtask

  task automatic push_run(input int s);
    ev_t e;
    for (int c = 0; c < NCH; c++) begin
      for (int t = 0; t < 32; t++) begin
        e = '{kind: 0, ch: c, val: t, eye: '0, ctap: '0};
        exp_q.push_back(e);
      end
      if (sc_centre[s][c] >= 0) begin
        e = '{kind: 0, ch: c, val: sc_centre[s][c], eye: '0, ctap: '0};
        exp_q.push_back(e);
      end
      for (int k = 0; k < sc_slips[s][c]; k++) begin
        e = '{kind: 1, ch: c, val: 0, eye: '0, ctap: '0};
        exp_q.push_back(e);
      end
    end
    e = '{kind: 2, ch: 0, val: int'({sc_locked[s], sc_fail[s]}), eye: sc_eye[s], ctap: sc_ctap[s]};
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.START = 1'b1;
    @(posedge clk);
    #1 bus.START = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   bus.BUSY, 0);
    check({tag, "_done"},   bus.DONE, 0);
    check({tag, "_locked"}, bus.LOCKED, 0);
    check({tag, "_fail"},   bus.FAIL, 0);
    check({tag, "_slip"},   bus.BITSLIP, 0);
    check({tag, "_ld"},     bus.DELAY_LD, 0);
    check({tag, "_dval"},   bus.DELAY_VALUE, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.DONE) break;
    end
    check({tag, "_done_seen"}, bus.DONE, 1);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.START = 1'b0;
    load_cfg(0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 RST_N = 1'b1;

    // Run aborted by reset in the middle of the channel-0 sweep
    push_run(0);
    pulse_start();
    repeat (300) @(posedge clk);
    #1 RST_N = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_reset");
    exp_q.delete();
    @(posedge clk);
    #1 RST_N = 1'b1;

    // Clean rerun of scenario 0 with a START pulse while busy
    push_run(0);
    pulse_start();
    repeat (1000) @(posedge clk);
    pulse_start();
    wait_done("run0");
    @(negedge clk);
    check("run0_locked", bus.LOCKED, 4'b0011);
    check("run0_fail",   bus.FAIL,   4'b1100);
    check("run0_busy",   bus.BUSY,   0);
    check("run0_queue_empty", exp_q.size(), 0);

    // START after DONE clears status the next cycle; boundary windows
    load_cfg(1);
    push_run(1);
    pulse_start();
    check("restart_done",   bus.DONE,   0);
    check("restart_locked", bus.LOCKED, 0);
    check("restart_fail",   bus.FAIL,   0);
    check("restart_busy",   bus.BUSY,   1);
    wait_done("run1");
    @(negedge clk);
    check("run1_locked", bus.LOCKED, 4'b1111);
    check("run1_fail",   bus.FAIL,   4'b0000);
    check("run1_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
